// File: rtl/measure_pkg.sv
// measure_pkg: shared constants, FSM state type and byte-select helper for the RX measurement stage.
//   OFS_*          byte offsets after SFD of the checked / captured frame fields
//   PREAMBLE_BYTE  GMII preamble octet
//   SFD_BYTE       GMII start-of-frame delimiter
//   state_t        frame-parse FSM states
//   be_byte        big-endian byte k (0 = MSB) of a 32-bit word
package measure_pkg;
   localparam logic [11:0] OFS_ETYPE = 12'd12;
   localparam logic [11:0] OFS_PROTO = 12'd23;
   localparam logic [11:0] OFS_MAGIC = 12'd42;
   localparam logic [11:0] OFS_TS = 12'd46;
   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE = 8'hD5;
   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;
   function automatic logic [7:0] be_byte(logic [31:0] w, logic [1:0] k);
      return w[8*(3-int'(k)) +: 8];
   endfunction
endpackage

// File: rtl/measure_window.sv
// measure_window: per-window accepted frame/byte accumulation, latched into the status outputs at window end.
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   inc                 one frame accepted this cycle
//   len                 length in bytes of the accepted frame
//   pps                 frames accepted in the last completed window
//   throughput          bits accepted in the last completed window
module measure_window #(
   parameter int SECOND_TICKS = 125_000_000
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        inc,
   input  logic [11:0] len,
   output logic [31:0] pps,
   output logic [31:0] throughput
);
   logic [31:0] tick, pkt_cnt, pkt_next;
   logic [28:0] byte_cnt, byte_next;
   logic [29:0] byte_sum;
   logic term;
   // next values include this cycle's acceptance so a frame ending on the terminal tick lands in the closing window
   always_comb begin
      term = tick == 32'(SECOND_TICKS - 1);
      pkt_next = (inc && pkt_cnt != '1) ? pkt_cnt + 32'd1 : pkt_cnt;
      byte_sum = {1'b0, byte_cnt} + (inc ? {18'd0, len} : 30'd0);
      byte_next = byte_sum[29] ? '1 : byte_sum[28:0];
   end
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tick <= '0;
         pkt_cnt <= '0;
         byte_cnt <= '0;
         pps <= '0;
         throughput <= '0;
      end else begin
         tick <= term ? '0 : tick + 32'd1;
         pkt_cnt <= term ? '0 : pkt_next;
         byte_cnt <= term ? '0 : byte_next;
         if (term) begin
            pps <= pkt_next;
            throughput <= {byte_next, 3'b000};
         end
      end
   end
endmodule

// File: rtl/measure_rx.sv
// measure_rx: GMII RX parser that accepts IPv4/UDP measurement frames and reports rate and one-way latency.
//   sys_clk, sys_rst_n  125 MHz clock, asynchronous active-low reset
//   gmii_rxd, gmii_rx_dv  GMII receive data / data valid
//   global_counter      free-running timestamp shared with the TX generator
//   rx_pps              accepted frames in the last completed window
//   rx_throughput       accepted bits in the last completed window
//   rx_latency          latency of the most recent accepted frame, in sys_clk ticks
//   rx_frame_ok         one-cycle pulse per accepted frame
module measure_rx
   import measure_pkg::*;
#(
   parameter int          SECOND_TICKS = 125_000_000,
   parameter logic [31:0] MAGIC = 32'hC0FFEE01,
   parameter int          MIN_LEN = 64
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [7:0]  gmii_rxd,
   input  logic        gmii_rx_dv,
   input  logic [31:0] global_counter,
   output logic [31:0] rx_pps,
   output logic [31:0] rx_throughput,
   output logic [31:0] rx_latency,
   output logic        rx_frame_ok
);
   state_t state;
   logic [11:0] idx;
   logic match;
   logic [23:0] ts_hi;
   logic [31:0] lat_tmp;
   logic in_magic, in_ts, chk, accept;
   logic [7:0] exp_b;
   always_comb begin
      in_magic = idx >= OFS_MAGIC && idx < OFS_MAGIC + 12'd4;
      in_ts = idx >= OFS_TS && idx < OFS_TS + 12'd3;
      chk = idx == OFS_ETYPE || idx == OFS_ETYPE + 12'd1 || idx == OFS_PROTO || in_magic;
      exp_b = idx == OFS_ETYPE ? 8'h08 : idx == OFS_PROTO ? 8'h11 : in_magic ? be_byte(MAGIC, 2'(idx - OFS_MAGIC)) : 8'h00;
      accept = state == DATA && !gmii_rx_dv && match && idx >= 12'(MIN_LEN);
   end
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= IDLE;
         idx <= '0;
         match <= 1'b0;
         ts_hi <= '0;
         lat_tmp <= '0;
         rx_latency <= '0;
         rx_frame_ok <= 1'b0;
      end else begin
         rx_frame_ok <= accept;
         if (accept) rx_latency <= lat_tmp;
         case (state)
            IDLE: if (gmii_rx_dv) state <= gmii_rxd == PREAMBLE_BYTE ? PREAMBLE : DROP;
            PREAMBLE:
               if (!gmii_rx_dv) state <= IDLE;
               else if (gmii_rxd == SFD_BYTE) begin
                  state <= DATA;
                  idx <= '0;
                  match <= 1'b1;
               end else if (gmii_rxd != PREAMBLE_BYTE) state <= DROP;
            DATA:
               if (!gmii_rx_dv) state <= IDLE;
               else begin
                  if (idx != 12'hFFF) idx <= idx + 12'd1;
                  if (chk && gmii_rxd != exp_b) match <= 1'b0;
                  if (in_ts) ts_hi[8*(2-int'(2'(idx - OFS_TS))) +: 8] <= gmii_rxd;
                  // last timestamp byte is taken straight off the wire, so the subtraction happens on its arrival
                  if (idx == OFS_TS + 12'd3) lat_tmp <= global_counter - {ts_hi, gmii_rxd};
               end
            DROP: if (!gmii_rx_dv) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   measure_window #(.SECOND_TICKS(SECOND_TICKS)) u_window (
      .sys_clk(sys_clk),
      .sys_rst_n(sys_rst_n),
      .inc(accept),
      .len(idx),
      .pps(rx_pps),
      .throughput(rx_throughput)
   );
endmodule

// File: tb/tb_measure_rx.sv
// tb_measure_rx: randomized self-checking bench for measure_rx against a frame-level reference model.
module tb_measure_rx;
   localparam int TICKS = 1000;
   localparam logic [31:0] MAGIC = 32'hC0FFEE01;
   logic clk = 1'b0, rst_n = 1'b0, dv = 1'b0;
   logic [7:0] rxd = 8'h00;
   logic [31:0] gc = 32'd0;
   logic [31:0] pps, thr, lat;
   logic ok;
   int checks = 0, errors = 0, edges = 0;
   logic [7:0] frm[$];
   int unsigned win_p[int];
   int unsigned win_b[int];
   logic [31:0] last_lat = 32'd0;

   measure_rx #(.SECOND_TICKS(TICKS), .MAGIC(MAGIC), .MIN_LEN(64)) dut (
      .sys_clk(clk),
      .sys_rst_n(rst_n),
      .gmii_rxd(rxd),
      .gmii_rx_dv(dv),
      .global_counter(gc),
      .rx_pps(pps),
      .rx_throughput(thr),
      .rx_latency(lat),
      .rx_frame_ok(ok)
   );

   always #4 clk = ~clk;
   // index of the next rising edge since reset release == DUT window tick phase
   always @(posedge clk or negedge rst_n) if (!rst_n) edges <= 0; else edges <= edges + 1;

   function automatic logic [7:0] rnd_byte();
      logic [7:0] b = 8'($urandom);
      return (b == 8'h55 || b == 8'hD5) ? 8'h00 : b;
   endfunction

   task automatic build(input int len, input logic [7:0] et_hi, input logic [7:0] proto, input logic [31:0] magic, input logic [31:0] ts);
      frm.delete();
      repeat (7) frm.push_back(8'h55);
      frm.push_back(8'hD5);
      for (int i = 0; i < len; i++) frm.push_back(rnd_byte());
      if (len >= 58) begin
         frm[20] = et_hi;
         frm[21] = 8'h00;
         frm[31] = proto;
         for (int k = 0; k < 4; k++) begin
            frm[50+k] = magic[8*(3-k) +: 8];
            frm[54+k] = ts[8*(3-k) +: 8];
         end
      end
   endtask

   task automatic send(input logic [31:0] gc49, input string name);
      int n, acc_edge;
      bit acc;
      n = frm.size() - 8;
      acc = 1'b0;
      if (n >= 64)
         acc = frm[20] == 8'h08 && frm[21] == 8'h00 && frm[31] == 8'h11 && {frm[50], frm[51], frm[52], frm[53]} == MAGIC;
      for (int i = 0; i < frm.size(); i++) begin
         @(posedge clk); #1;
         dv = 1'b1;
         rxd = frm[i];
         gc = (i == 57) ? gc49 : $urandom;
      end
      @(posedge clk); #1;
      dv = 1'b0;
      rxd = 8'($urandom);
      acc_edge = edges;
      if (acc) begin
         win_p[acc_edge / TICKS] = win_p[acc_edge / TICKS] + 1;
         win_b[acc_edge / TICKS] = win_b[acc_edge / TICKS] + n;
         last_lat = gc49 - {frm[54], frm[55], frm[56], frm[57]};
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if (ok !== acc) begin errors++; $display("FAIL %s pulse: got %b want %b", name, ok, acc); end
      checks++;
      if (lat !== last_lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, last_lat); end
      @(negedge clk);
      checks++;
      if (ok !== 1'b0) begin errors++; $display("FAIL %s pulse_width: got %b want 0", name, ok); end
   endtask

   task automatic wait_phase(input int ph);
      int g = 0;
      @(negedge clk);
      while (edges % TICKS != ph && g < 2 * TICKS) begin @(negedge clk); g++; end
      if (edges % TICKS != ph) begin checks++; errors++; $display("FAIL wait_phase timeout: got %0d want %0d", edges % TICKS, ph); end
   endtask

   task automatic check_window(input int w, input string name);
      int g = 0;
      logic [31:0] ep, et;
      @(negedge clk);
      while (edges < (w + 1) * TICKS && g < 3 * TICKS) begin @(negedge clk); g++; end
      ep = win_p.exists(w) ? win_p[w] : 0;
      et = win_b.exists(w) ? win_b[w] * 8 : 0;
      checks++;
      if (pps !== ep) begin errors++; $display("FAIL %s pps: got %0d want %0d", name, pps, ep); end
      checks++;
      if (thr !== et) begin errors++; $display("FAIL %s throughput: got %0d want %0d", name, thr, et); end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({pps, thr, lat, ok} !== 97'd0) begin
         errors++;
         $display("FAIL %s outputs: got pps=%0d thr=%0d lat=%0d ok=%b want all 0", name, pps, thr, lat, ok);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      build(64, 8'h08, 8'h11, MAGIC, 32'd1000);
      send(32'd1250, "single");
      checks++;
      if (lat !== 32'd250) begin errors++; $display("FAIL single_lat250: got %0d want 250", lat); end
   endtask

   task automatic test_window();
      int w;
      wait_phase(5);
      w = edges / TICKS;
      repeat (10) begin
         build(64, 8'h08, 8'h11, MAGIC, $urandom);
         send($urandom, "window_frame");
      end
      check_window(w, "window");
      checks++;
      if (pps !== 32'd10 || thr !== 32'd5120) begin errors++; $display("FAIL window_const: got %0d/%0d want 10/5120", pps, thr); end
   endtask

   task automatic test_reject();
      int w;
      wait_phase(5);
      w = edges / TICKS;
      build(64, 8'h08, 8'h11, 32'hC0FFEE02, 32'd5);
      send(32'd9, "bad_magic");
      build(64, 8'h08, 8'h06, MAGIC, 32'd5);
      send(32'd9, "bad_proto");
      build(60, 8'h08, 8'h11, MAGIC, 32'd5);
      send(32'd9, "runt");
      check_window(w, "reject");
   endtask

   task automatic test_wrap();
      build(64, 8'h08, 8'h11, MAGIC, 32'hFFFFFFF0);
      send(32'h00000010, "wrap");
      checks++;
      if (lat !== 32'd32) begin errors++; $display("FAIL wrap_lat32: got %0d want 32", lat); end
   endtask

   task automatic test_boundary();
      int w;
      wait_phase(0);
      wait_phase(926);
      w = edges / TICKS;
      build(64, 8'h08, 8'h11, MAGIC, $urandom);
      send($urandom, "boundary_frame");
      check_window(w, "boundary_close");
      checks++;
      if (pps !== 32'd1) begin errors++; $display("FAIL boundary_pps1: got %0d want 1", pps); end
      check_window(w + 1, "boundary_next");
      checks++;
      if (pps !== 32'd0) begin errors++; $display("FAIL boundary_pps0: got %0d want 0", pps); end
   endtask

   task automatic test_reset_midframe();
      bit seen = 1'b0;
      build(64, 8'h08, 8'h11, MAGIC, 32'd1000);
      for (int i = 0; i <= 38; i++) begin
         @(posedge clk); #1;
         dv = 1'b1;
         rxd = frm[i];
         gc = $urandom;
      end
      #2 rst_n = 1'b0;
      @(negedge clk);
      check_zero("midreset_async");
      @(negedge clk);
      check_zero("midreset_held");
      win_p.delete();
      win_b.delete();
      last_lat = 32'd0;
      rst_n = 1'b1;
      for (int i = 39; i < frm.size(); i++) begin
         @(posedge clk); #1;
         rxd = frm[i];
         gc = (i == 57) ? 32'd1250 : $urandom;
         @(negedge clk);
         seen |= ok;
      end
      @(posedge clk); #1;
      dv = 1'b0;
      repeat (3) begin @(negedge clk); seen |= ok; end
      checks++;
      if (seen !== 1'b0 || lat !== 32'd0) begin errors++; $display("FAIL midreset_discard: got ok=%b lat=%0d want 0/0", seen, lat); end
      build(64, 8'h08, 8'h11, MAGIC, 32'd77);
      send(32'd100, "post_reset");
   endtask

   task automatic test_random();
      int kind, len;
      logic [7:0] et, pr;
      logic [31:0] mg;
      repeat (25) begin
         kind = $urandom_range(0, 5);
         len = (kind == 4) ? $urandom_range(58, 63) : $urandom_range(64, 120);
         et = (kind == 1) ? 8'h86 : 8'h08;
         pr = (kind == 2) ? 8'h06 : 8'h11;
         mg = (kind == 3) ? MAGIC ^ (32'h1 << $urandom_range(0, 31)) : MAGIC;
         build(len, et, pr, mg, $urandom);
         send($urandom, "random");
      end
      check_window(edges / TICKS, "random_window");
   endtask

   initial begin
      test_reset();
      test_single();
      test_window();
      test_reject();
      test_wrap();
      test_boundary();
      test_reset_midframe();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
